// File: rtl/segment7_pkg.sv
// rtl/segment7_pkg.sv - shared seven-segment decode table, bit order and FSM state type
package segment7_pkg;

    // Segment word bit positions: seg[6:0] = {a,b,c,d,e,f,g}
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // All segments off; a stable blank is silently ignored rather than flagged
    localparam logic [6:0] BLANK = 7'h00;

    // Entry i is the segment pattern that displays hex value i
    localparam logic [15:0][6:0] DECODE_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/segment7_lookup.sv
// rtl/segment7_lookup.sv - combinational segment pattern to hex value lookup
module segment7_lookup
    import segment7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] value
);

    // Search the shared table; the first matching entry wins
    always_comb begin
        hit   = 1'b0;
        value = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && (seg == DECODE_TABLE[i])) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/segment7_capture.sv
// rtl/segment7_capture.sv - debounced capture of a multiplexed 4-digit seven-segment display
module segment7_capture
    import segment7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic [3:0]  com,
    output logic [15:0] hex_out,
    output logic        frame_valid,
    output logic        bad_pat,
    output logic [1:0]  bad_digit
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    // sample = {com[3:0], a,b,c,d,e,f,g}; prev is the sample seen one cycle earlier
    logic [10:0]     sample_q, sample_d;
    logic [10:0]     prev_q, prev_d;
    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0][3:0] digits_q, digits_d;
    logic [3:0]      present_q, present_d;
    logic [15:0]     hex_out_q, hex_out_d;
    logic            frame_valid_q, frame_valid_d;
    logic            bad_pat_q, bad_pat_d;
    logic [1:0]      bad_digit_q, bad_digit_d;

    logic            accept;
    logic            samp_oh;
    logic            same;
    logic [1:0]      k;
    logic            hit;
    logic [3:0]      value;

    assign sample_d = {com, a, b, c, d, e, f, g};
    assign prev_d   = sample_q;
    assign samp_oh  = is_one_hot(sample_q[10:7]);
    assign same     = (sample_q == prev_q);
    assign k        = onehot_index(sample_q[10:7]);

    segment7_lookup u_lookup (
        .seg   (sample_q[6:0]),
        .hit   (hit),
        .value (value)
    );

    // Stability FSM: counts identical samples and fires a single accept per stable run
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (samp_oh) begin
                    state_d = ST_COUNT;
                    cnt_d   = 8'd1;
                end
            end
            ST_COUNT: begin
                if (!samp_oh) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 8'd1;
                    if (cnt_d == STABLE) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (!same) begin
                    state_d = samp_oh ? ST_COUNT : ST_IDLE;
                    cnt_d   = samp_oh ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Digit store and frame assembly; an accept on the frame-clear edge survives the clear
    always_comb begin
        digits_d      = digits_q;
        present_d     = (present_q == 4'hF) ? 4'h0 : present_q;
        hex_out_d     = (present_q == 4'hF) ? digits_q : hex_out_q;
        frame_valid_d = (present_q == 4'hF);
        bad_pat_d     = 1'b0;
        bad_digit_d   = bad_digit_q;
        if (accept) begin
            if (hit) begin
                digits_d[k]  = value;
                present_d[k] = 1'b1;
            end else if (sample_q[6:0] != BLANK) begin
                bad_pat_d   = 1'b1;
                bad_digit_d = k;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q      <= '0;
            prev_q        <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            digits_q      <= '0;
            present_q     <= '0;
            hex_out_q     <= '0;
            frame_valid_q <= 1'b0;
            bad_pat_q     <= 1'b0;
            bad_digit_q   <= '0;
        end else begin
            sample_q      <= sample_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            present_q     <= present_d;
            hex_out_q     <= hex_out_d;
            frame_valid_q <= frame_valid_d;
            bad_pat_q     <= bad_pat_d;
            bad_digit_q   <= bad_digit_d;
        end
    end

    assign hex_out     = hex_out_q;
    assign frame_valid = frame_valid_q;
    assign bad_pat     = bad_pat_q;
    assign bad_digit   = bad_digit_q;

endmodule
